// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the associative data cache.
package dcache_pkg;

  // Controller states; a miss walks WRITEBACK (if needed), FETCH, UPDATE.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Ceiling log2, used for the offset and index widths.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: per-set valid/dirty/tag/data storage with hit compare.
module dcache_way import dcache_pkg::*; #(
  parameter int DATA_W          = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  parameter int TAG_W           = 3,
  parameter int OFFSET_W        = clog2(WORDS_PER_BLOCK),
  parameter int INDEX_W         = clog2(NUM_SETS),
  parameter int BLOCK_W         = DATA_W * WORDS_PER_BLOCK
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [TAG_W-1:0]    tag,
  input  logic                word_we,
  input  logic [DATA_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [BLOCK_W-1:0]  fill_data,
  output logic                hit,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag_out,
  output logic [DATA_W-1:0]   word_out,
  output logic [BLOCK_W-1:0]  block_out
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];

  // Status bits: the only state cleared by reset; a fill is clean, a store dirties.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage: whole-block fill or single-word store.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= fill_data;
    end else if (word_we) begin
      data_q[index][offset*DATA_W +: DATA_W] <= word_data;
    end
  end

  assign valid     = valid_q[index];
  assign dirty     = dirty_q[index];
  assign tag_out   = tag_q[index];
  assign block_out = data_q[index];
  assign word_out  = data_q[index][offset*DATA_W +: DATA_W];
  assign hit       = valid_q[index] & (tag_q[index] == tag);

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate data cache with 1 or 2 ways and per-set LRU.
// CPU handshake: a request (READ|WRITE) is complete in the cycle BUSYWAIT=0;
// the CPU holds ADDRESS/WRITEDATA stable while BUSYWAIT=1. Memory handshake:
// mem_read/mem_write stay high until memory has raised and then dropped
// mem_busywait; the request drops in the following state.
module dcache_assoc import dcache_pkg::*; #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  parameter int WAYS            = 1
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         READ,
  input  logic                                         WRITE,
  input  logic [ADDR_W-1:0]                            ADDRESS,
  input  logic [DATA_W-1:0]                            WRITEDATA,
  output logic [DATA_W-1:0]                            READDATA,
  output logic                                         BUSYWAIT,
  output logic                                         mem_read,
  output logic                                         mem_write,
  output logic [ADDR_W-clog2(WORDS_PER_BLOCK)-1:0]     mem_address,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0]            mem_writedata,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0]            mem_readdata,
  input  logic                                         mem_busywait
);

  localparam int OFFSET_W = clog2(WORDS_PER_BLOCK);
  localparam int INDEX_W  = clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = DATA_W * WORDS_PER_BLOCK;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  assign {addr_tag, addr_index, addr_offset} = ADDRESS;

  state_t state_q, state_d;
  logic   started_q;
  logic   victim_q, victim_d, vic_sel;
  logic   request, is_write, hit_accept;
  logic   any_hit, hit_way, lru_bit;
  logic   vic_valid, vic_dirty;
  logic [TAG_W-1:0]   vic_tag;
  logic [BLOCK_W-1:0] vic_block;
  logic [DATA_W-1:0]  hit_word;

  logic [WAYS-1:0]    way_hit, way_valid, way_dirty, word_we, fill_we;
  logic [TAG_W-1:0]   way_tag   [WAYS];
  logic [DATA_W-1:0]  way_word  [WAYS];
  logic [BLOCK_W-1:0] way_block [WAYS];

  // READ wins when both strobes are high.
  assign request    = READ | WRITE;
  assign is_write   = WRITE & ~READ;
  assign hit_accept = request & (state_q == IDLE) & any_hit;
  assign BUSYWAIT   = request & ~((state_q == IDLE) & any_hit);
  assign READDATA   = any_hit ? hit_word : '0;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign word_we[g] = hit_accept & is_write & (hit_way == 1'(g));
    assign fill_we[g] = (state_q == UPDATE) & (victim_q == 1'(g));
    dcache_way #(
      .DATA_W(DATA_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK), .NUM_SETS(NUM_SETS),
      .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .BLOCK_W(BLOCK_W)
    ) u_way (
      .CLK(CLK), .RESET(RESET), .index(addr_index), .offset(addr_offset), .tag(addr_tag),
      .word_we(word_we[g]), .word_data(WRITEDATA), .fill_we(fill_we[g]), .fill_data(mem_readdata),
      .hit(way_hit[g]), .valid(way_valid[g]), .dirty(way_dirty[g]), .tag_out(way_tag[g]),
      .word_out(way_word[g]), .block_out(way_block[g])
    );
  end

  // Hit detection and word select across ways (at most one way can hit).
  always_comb begin
    any_hit  = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        any_hit  = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  // LRU bit per set names the way to evict next; only exists with two ways.
  if (WAYS == 2) begin : g_lru
    logic [NUM_SETS-1:0] lru_q;
    // Fill and hit both mark the touched way as most recent.
    always_ff @(posedge CLK) begin
      if (!RESET) lru_q <= '0;
      else if (state_q == UPDATE) lru_q[addr_index] <= ~victim_q;
      else if (hit_accept) lru_q[addr_index] <= ~hit_way;
    end
    assign lru_bit = lru_q[addr_index];
  end else begin : g_no_lru
    assign lru_bit = 1'b0;
  end

  // Victim choice: first invalid way (way 0 first), otherwise the LRU way.
  always_comb begin
    victim_d = 1'b0;
    if (WAYS == 2) begin
      if (!way_valid[0]) victim_d = 1'b0;
      else if (!way_valid[WAYS-1]) victim_d = 1'b1;
      else victim_d = lru_bit;
    end
  end

  // Victim line fields: live choice while IDLE, latched choice during the miss.
  always_comb begin
    vic_sel   = (state_q == IDLE) ? victim_d : victim_q;
    vic_valid = 1'b0;
    vic_dirty = 1'b0;
    vic_tag   = '0;
    vic_block = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vic_sel == 1'(w)) begin
        vic_valid = way_valid[w];
        vic_dirty = way_dirty[w];
        vic_tag   = way_tag[w];
        vic_block = way_block[w];
      end
    end
  end

  // Next state and memory-side outputs.
  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      IDLE: begin
        if (request && !any_hit) state_d = (vic_valid && vic_dirty) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {vic_tag, addr_index};
        mem_writedata = vic_block;
        if (started_q && !mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
        if (started_q && !mem_busywait) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, memory-started flag (cleared on every state change) and latched victim.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      victim_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != state_d) started_q <= 1'b0;
      else if (mem_busywait) started_q <= 1'b1;
      if (state_q == IDLE) victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: three configurations side by side, a behavioural
// memory, and a byte-level truth model plus a recency-ordered residency model.
module tb_dcache_assoc;

  localparam int NK = 3;  // 0: 1-way 4x8, 1: 2-way 4x8, 2: 2-way 8x4

  function automatic int cfg_wpb(input int k);  return (k == 2) ? 8 : 4; endfunction
  function automatic int cfg_sets(input int k); return (k == 2) ? 4 : 8; endfunction
  function automatic int cfg_ways(input int k); return (k == 0) ? 1 : 2; endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       rd_i [NK];
  logic       wr_i [NK];
  logic [7:0] addr_i [NK];
  logic [7:0] wdata_i [NK];
  logic [63:0] mrdata_i [NK];
  logic        mbusy_i [NK];
  wire [7:0]  rdata_o [NK];
  wire        bw_o [NK];
  wire        mrd_o [NK];
  wire        mwr_o [NK];
  wire [5:0]  maddr_o [NK];
  wire [63:0] mwdata_o [NK];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NK; g++) begin : g_dut
    localparam int WPB  = (g == 2) ? 8 : 4;
    localparam int SETS = (g == 2) ? 4 : 8;
    localparam int WY   = (g == 0) ? 1 : 2;
    localparam int OW   = (WPB == 8) ? 3 : 2;
    localparam int BW   = 8 * WPB;
    wire [8-OW-1:0] maddr_l;
    wire [BW-1:0]   mwdata_l;
    dcache_assoc #(.ADDR_W(8), .DATA_W(8), .WORDS_PER_BLOCK(WPB), .NUM_SETS(SETS), .WAYS(WY)) u_dut (
      .CLK(clk), .RESET(rst_n), .READ(rd_i[g]), .WRITE(wr_i[g]), .ADDRESS(addr_i[g]),
      .WRITEDATA(wdata_i[g]), .READDATA(rdata_o[g]), .BUSYWAIT(bw_o[g]),
      .mem_read(mrd_o[g]), .mem_write(mwr_o[g]), .mem_address(maddr_l),
      .mem_writedata(mwdata_l), .mem_readdata(mrdata_i[g][BW-1:0]), .mem_busywait(mbusy_i[g])
    );
    assign maddr_o[g]  = 6'(maddr_l);
    assign mwdata_o[g] = 64'(mwdata_l);
  end

  // ---------------- memory model ----------------
  logic [7:0] mem_init  [NK][256];
  logic [7:0] mem_store [NK][256];
  int         mem_lat [NK];
  int         mcnt [NK];
  bit         mcool [NK];

  // Busy for mem_lat cycles after noticing a request, then completes and
  // ignores the still-high request for one cycle while the cache moves on.
  always @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        mbusy_i[k] <= 1'b0;
        mcnt[k]    <= 0;
        mcool[k]   <= 1'b0;
        for (int a = 0; a < 256; a++) mem_store[k][a] <= mem_init[k][a];
      end else if (mbusy_i[k]) begin
        if (mcnt[k] <= 1) begin
          mbusy_i[k] <= 1'b0;
          mcool[k]   <= 1'b1;
          for (int b = 0; b < cfg_wpb(k); b++) begin
            if (mwr_o[k]) mem_store[k][int'(maddr_o[k]) * cfg_wpb(k) + b] <= mwdata_o[k][8*b +: 8];
            else mrdata_i[k][8*b +: 8] <= mem_store[k][int'(maddr_o[k]) * cfg_wpb(k) + b];
          end
        end else begin
          mcnt[k] <= mcnt[k] - 1;
        end
      end else if (mcool[k]) begin
        mcool[k] <= 1'b0;
      end else if (mrd_o[k] || mwr_o[k]) begin
        mbusy_i[k] <= 1'b1;
        mcnt[k]    <= mem_lat[k];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] truth [NK][256];   // latest stored value of every byte
  bit sv [NK][8][2];
  bit sd [NK][8][2];
  int st [NK][8][2];
  int stime [NK][8][2];          // last-touch timestamp for LRU
  int now_t = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int a = 0; a < 256; a++) truth[k][a] = mem_init[k][a];
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 2; w++) begin sv[k][s][w] = 0; sd[k][s][w] = 0; end
    end
  endtask

  logic [7:0]  last_got;
  int          last_stall;
  bit          last_saw_wb, last_saw_rd, last_miss;
  logic [5:0]  last_wb_addr, last_rd_addr;
  logic [63:0] last_wb_data;

  // One CPU access with per-cycle checks of the memory side and final checks
  // of stall length, traffic length and load data.
  task automatic access(input int k, input bit w, input logic [7:0] a, input logic [7:0] d);
    int wpb, sets, blk, set, tag, hs, vic, lat, exp_wbc, exp_rdc;
    int wb_cyc, rd_cyc, stall, first_wb, first_rd;
    bit done, exp_wb;
    logic [63:0] exp_blk;
    wpb = cfg_wpb(k); sets = cfg_sets(k);
    blk = int'(a) / wpb; set = blk % sets; tag = blk / sets;
    hs = -1;
    for (int s = 0; s < cfg_ways(k); s++) if (sv[k][set][s] && st[k][set][s] == tag) hs = s;
    vic = 0; exp_wb = 0; exp_blk = '0;
    if (hs < 0) begin
      vic = -1;
      for (int s = cfg_ways(k) - 1; s >= 0; s--) if (!sv[k][set][s]) vic = s;
      if (vic < 0) begin
        vic = 0;
        for (int s = 1; s < cfg_ways(k); s++) if (stime[k][set][s] < stime[k][set][vic]) vic = s;
      end
      exp_wb = sv[k][set][vic] && sd[k][set][vic];
      for (int b = 0; b < wpb; b++) exp_blk[8*b +: 8] = truth[k][(st[k][set][vic] * sets + set) * wpb + b];
    end
    lat = int'($urandom_range(1, 3));
    mem_lat[k] = lat;
    @(posedge clk); #1;
    rd_i[k] = ~w; wr_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
    wb_cyc = 0; rd_cyc = 0; stall = 0; done = 0; first_wb = -1; first_rd = -1;
    last_saw_wb = 0; last_saw_rd = 0; last_wb_addr = '0; last_rd_addr = '0; last_wb_data = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      chk("mem_rd_wr_exclusive", {63'd0, mrd_o[k] & mwr_o[k]}, 64'd0);
      if (mwr_o[k]) begin
        if (first_wb < 0) first_wb = c;
        wb_cyc++; last_saw_wb = 1; last_wb_addr = maddr_o[k]; last_wb_data = mwdata_o[k];
        chk("wb_address", {58'd0, maddr_o[k]}, 64'((st[k][set][vic] * sets + set)));
        chk("wb_data", mwdata_o[k], exp_blk);
      end
      if (mrd_o[k]) begin
        if (first_rd < 0) first_rd = c;
        rd_cyc++; last_saw_rd = 1; last_rd_addr = maddr_o[k];
        chk("fetch_address", {58'd0, maddr_o[k]}, 64'(blk));
      end
      if (bw_o[k]) begin
        stall++;
        @(posedge clk);
      end else begin
        done = 1;
      end
    end
    chk("access_timeout", {63'd0, done}, 64'd1);
    exp_wbc = exp_wb ? lat + 2 : 0;
    exp_rdc = (hs < 0) ? lat + 2 : 0;
    chk("writeback_cycles", 64'(wb_cyc), 64'(exp_wbc));
    chk("fetch_cycles", 64'(rd_cyc), 64'(exp_rdc));
    chk("stall_cycles", 64'(stall), 64'((hs < 0) ? 2 + exp_wbc + exp_rdc : 0));
    if (exp_wb) chk("wb_before_fetch", {63'd0, first_wb < first_rd}, 64'd1);
    last_got = rdata_o[k];
    if (!w) chk("readdata", {56'd0, rdata_o[k]}, {56'd0, truth[k][a]});
    @(posedge clk); #1;
    rd_i[k] = 0; wr_i[k] = 0;
    last_stall = stall; last_miss = (hs < 0);
    if (hs < 0) begin
      hs = vic; sv[k][set][hs] = 1; sd[k][set][hs] = 0; st[k][set][hs] = tag;
    end
    now_t++;
    stime[k][set][hs] = now_t;
    if (w) begin sd[k][set][hs] = 1; truth[k][a] = d; end
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        chk("idle_busywait", {63'd0, bw_o[k]}, 64'd0);
        chk("idle_mem_read", {63'd0, mrd_o[k]}, 64'd0);
        chk("idle_mem_write", {63'd0, mwr_o[k]}, 64'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got=running want=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit seen;
    for (int k = 0; k < NK; k++) begin
      rd_i[k] = 0; wr_i[k] = 0; addr_i[k] = '0; wdata_i[k] = '0; mem_lat[k] = 1;
      for (int a = 0; a < 256; a++) mem_init[k][a] = 8'($urandom);
    end
    mem_init[0][0] = 8'hAA; mem_init[0][1] = 8'hBB; mem_init[0][2] = 8'hCC; mem_init[0][3] = 8'hDD;
    mem_init[1][0] = 8'hAA; mem_init[1][1] = 8'hBB; mem_init[1][2] = 8'hCC; mem_init[1][3] = 8'hDD;
    for (int b = 0; b < 8; b++) mem_init[2][8 + b] = 8'h10 + 8'(b);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state of every configuration.
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk("rst_busywait", {63'd0, bw_o[k]}, 64'd0);
      chk("rst_readdata", {56'd0, rdata_o[k]}, 64'd0);
      chk("rst_mem_read", {63'd0, mrd_o[k]}, 64'd0);
      chk("rst_mem_write", {63'd0, mwr_o[k]}, 64'd0);
      chk("rst_mem_address", {58'd0, maddr_o[k]}, 64'd0);
      chk("rst_mem_writedata", mwdata_o[k], 64'd0);
    end

    // Cold miss, then hit in the same line.
    access(0, 0, 8'h00, 8'h00);
    chk("t1_miss_stalls", {63'd0, last_stall != 0}, 64'd1);
    chk("t1_fetch_addr", {58'd0, last_rd_addr}, 64'h00);
    chk("t1_data", {56'd0, last_got}, 64'hAA);
    access(0, 0, 8'h01, 8'h00);
    chk("t1_hit_data", {56'd0, last_got}, 64'hBB);
    chk("t1_hit_stall", 64'(last_stall), 64'd0);
    chk("t1_hit_no_fetch", {63'd0, last_saw_rd}, 64'd0);

    // Write hit then read back.
    access(0, 1, 8'h02, 8'h55);
    chk("t2_write_stall", 64'(last_stall), 64'd0);
    access(0, 0, 8'h02, 8'h00);
    chk("t2_readback", {56'd0, last_got}, 64'h55);
    chk("t2_no_traffic", {62'd0, last_saw_rd, last_saw_wb}, 64'd0);

    // Conflict miss on the direct-mapped cache forces writeback first.
    access(0, 0, 8'h20, 8'h00);
    chk("t3_wb_seen", {63'd0, last_saw_wb}, 64'd1);
    chk("t3_wb_addr", {58'd0, last_wb_addr}, 64'h00);
    chk("t3_wb_data", last_wb_data, 64'hDD55BBAA);
    chk("t3_fetch_addr", {58'd0, last_rd_addr}, 64'h08);
    chk("t3_data", {56'd0, last_got}, {56'd0, mem_init[0][8'h20]});

    // Two-way LRU: 0x40 must evict 0x20, not the recently hit 0x00.
    access(1, 0, 8'h00, 8'h00);
    access(1, 0, 8'h20, 8'h00);
    access(1, 0, 8'h00, 8'h00);
    chk("t4_hit_0x00", 64'(last_stall), 64'd0);
    access(1, 0, 8'h40, 8'h00);
    access(1, 0, 8'h00, 8'h00);
    chk("t4_0x00_still_hits", 64'(last_stall), 64'd0);
    access(1, 0, 8'h20, 8'h00);
    chk("t4_0x20_misses", {63'd0, last_miss && last_stall != 0}, 64'd1);

    // Reset in the middle of a fetch aborts it.
    mem_lat[1] = 3;
    @(posedge clk); #1;
    rd_i[1] = 1; addr_i[1] = 8'h60;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mrd_o[1]) seen = 1;
    end
    chk("t5_fetch_reached", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; rd_i[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t5_mem_read_dropped", {63'd0, mrd_o[1]}, 64'd0);
    chk("t5_busywait_dropped", {63'd0, bw_o[1]}, 64'd0);
    access(1, 0, 8'h00, 8'h00);
    chk("t5_refetch_after_reset", {63'd0, last_miss && last_stall != 0}, 64'd1);

    // Eight-word blocks, four sets.
    access(2, 0, 8'h0F, 8'h00);
    chk("t6_fetch_addr", {58'd0, last_rd_addr}, 64'h01);
    chk("t6_data", {56'd0, last_got}, 64'h17);

    idle_check(3);

    // Randomised traffic over a few tags per set to force conflicts.
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 120; i++) begin
        int t, s, o;
        t = int'($urandom_range(0, 3));
        s = int'($urandom_range(0, cfg_sets(k) - 1));
        o = int'($urandom_range(0, cfg_wpb(k) - 1));
        access(k, ($urandom_range(0, 9) < 4), 8'((t * cfg_sets(k) + s) * cfg_wpb(k) + o), 8'($urandom));
        if ($urandom_range(0, 7) == 0) idle_check(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
